// File: rtl/ps2_rx_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ps2_rx_ctrl_if
//  Purpose  : PS/2 pin pair plus decoded-byte / error-pulse bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface ps2_rx_ctrl_if;
    logic       kb_clk;
    logic       kb_data;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       parity_err;
    logic       frame_err;
    logic       timeout_err;
    logic       busy;

    // master: keyboard pins and result consumer; slave: the receive controller
    modport master (
        output kb_clk, kb_data,
        input  scan_code, scan_valid, parity_err, frame_err, timeout_err, busy
    );
    modport slave (
        input  kb_clk, kb_data,
        output scan_code, scan_valid, parity_err, frame_err, timeout_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ps2_rx_ctrl
//  Purpose  : PS/2 keyboard frame receiver with parity/stop/timeout checking.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_rx_ctrl #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ps2_rx_ctrl_if.slave     if_ps2
);

    localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    logic              r_clk_s1;
    logic              r_clk_s2;
    logic              r_clk_prev;
    logic              r_dat_s1;
    logic              r_dat_s2;
    logic [1:0]        r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_par;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [7:0]        r_scan_code;
    logic              r_scan_valid;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              r_timeout_err;

    logic w_fall;
    logic w_timeout;
    logic w_ok_par;
    logic w_ok_stop;

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_timeout = (r_state != c_ST_IDLE) && (r_to_cnt == c_TO_LAST);
    assign w_ok_par  = ^{r_shift, r_par};
    assign w_ok_stop = r_dat_s2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_s1      <= 1'b1;
            r_clk_s2      <= 1'b1;
            r_clk_prev    <= 1'b1;
            r_dat_s1      <= 1'b1;
            r_dat_s2      <= 1'b1;
            r_state       <= c_ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            r_par         <= 1'b0;
            r_to_cnt      <= '0;
            r_scan_code   <= 8'h00;
            r_scan_valid  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_clk_s1      <= if_ps2.kb_clk;
            r_clk_s2      <= r_clk_s1;
            r_clk_prev    <= r_clk_s2;
            r_dat_s1      <= if_ps2.kb_data;
            r_dat_s2      <= r_dat_s1;
            r_scan_valid  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;

            if ((r_state == c_ST_IDLE) || w_fall) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TO_ONE;
            end

            // A timeout takes priority; a coincident edge is deliberately dropped.
            if (w_timeout) begin
                r_state       <= c_ST_IDLE;
                r_timeout_err <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= c_ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    c_ST_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_ST_PARITY;
                        end
                    end
                    c_ST_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= c_ST_STOP;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        if (w_ok_par && w_ok_stop) begin
                            r_scan_code  <= r_shift;
                            r_scan_valid <= 1'b1;
                        end
                        r_parity_err <= ~w_ok_par;
                        r_frame_err  <= ~w_ok_stop;
                    end
                endcase
            end
        end
    end

    assign if_ps2.scan_code   = r_scan_code;
    assign if_ps2.scan_valid  = r_scan_valid;
    assign if_ps2.parity_err  = r_parity_err;
    assign if_ps2.frame_err   = r_frame_err;
    assign if_ps2.timeout_err = r_timeout_err;
    assign if_ps2.busy        = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ps2_rx_ctrl
//  Purpose  : Directed frames against an event-queue model of ps2_rx_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_rx_ctrl;

    localparam int c_TO   = 100;
    // Keyboard half-period in clk cycles; a full period stays well under c_TO.
    localparam int c_HALF = 20;
    localparam int c_FAR  = 2147483647;

    typedef struct {
        int         at;
        bit         valid;
        logic [7:0] code;
        bit         perr;
        bit         ferr;
        bit         terr;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_rx_ctrl_if bus ();

    ps2_rx_ctrl #(
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .if_ps2 (bus)
    );

    ev_t        evq[$];
    ev_t        m_ev;
    logic [7:0] m_code  = 8'h00;
    int         busy_lo = 0;
    int         busy_hi = 0;
    int         rst_at  = -1;
    bit         chk_en  = 1'b0;
    int         n_valid = 0;
    int         n_to    = 0;
    int         checks  = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the expected-result queue.
    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc == rst_at) begin
                m_code = 8'h00;
                evq.delete();
            end
            m_ev = '{default: 0};
            if (evq.size() > 0 && evq[0].at == cyc) begin
                m_ev = evq.pop_front();
                if (m_ev.valid) m_code = m_ev.code;
            end
            check("scan_valid",  {31'd0, bus.scan_valid},  {31'd0, m_ev.valid});
            check("parity_err",  {31'd0, bus.parity_err},  {31'd0, m_ev.perr});
            check("frame_err",   {31'd0, bus.frame_err},   {31'd0, m_ev.ferr});
            check("timeout_err", {31'd0, bus.timeout_err}, {31'd0, m_ev.terr});
            check("scan_code",   {24'd0, bus.scan_code},   {24'd0, m_code});
            check("busy",        {31'd0, bus.busy},        {31'd0, (cyc >= busy_lo && cyc < busy_hi)});
            if (bus.scan_valid)  n_valid++;
            if (bus.timeout_err) n_to++;
        end
    end

    task automatic fall_low(input bit b, input int lead, output int t);
        bus.kb_data = b;
        repeat (lead) @(negedge clk);
        bus.kb_clk = 1'b0;
        t = cyc;
    endtask

    task automatic release_clk();
        repeat (c_HALF) @(negedge clk);
        bus.kb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop, input int lead);
        int  t;
        bit  par;
        bit  ok_par;
        ev_t e;
        par = ~(^d) ^ par_flip;
        fall_low(1'b0, lead, t);
        busy_lo = t + 3;
        busy_hi = c_FAR;
        release_clk();
        for (int i = 0; i < 8; i++) begin
            fall_low(d[i], c_HALF, t);
            release_clk();
        end
        fall_low(par, c_HALF, t);
        release_clk();
        fall_low(stop, c_HALF, t);
        ok_par  = ((^d) ^ par) == 1'b1;
        e.at    = t + 3;
        e.valid = ok_par && stop;
        e.code  = d;
        e.perr  = !ok_par;
        e.ferr  = !stop;
        e.terr  = 1'b0;
        evq.push_back(e);
        busy_hi = t + 3;
        release_clk();
        bus.kb_data = 1'b1;
    endtask

    // Start bit plus (nfalls-1) data bits, then the keyboard goes quiet.
    task automatic partial(input logic [7:0] d, input int nfalls, output int last_t);
        int t;
        fall_low(1'b0, c_HALF, t);
        busy_lo = t + 3;
        busy_hi = c_FAR;
        release_clk();
        for (int i = 0; i < nfalls - 1; i++) begin
            fall_low(d[i], c_HALF, t);
            release_clk();
        end
        bus.kb_data = 1'b1;
        last_t = t;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  t;
        ev_t e;
        bus.kb_clk  = 1'b1;
        bus.kb_data = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_scan_code",   {24'd0, bus.scan_code},   32'h00);
        check("rst_scan_valid",  {31'd0, bus.scan_valid},  32'h0);
        check("rst_errors",      {29'd0, bus.parity_err, bus.frame_err, bus.timeout_err}, 32'h0);
        check("rst_busy",        {31'd0, bus.busy},        32'h0);
        rst = 1'b1;
        chk_en = 1'b1;
        repeat (10) @(negedge clk);

        send_frame(8'h1C, 1'b0, 1'b1, c_HALF);
        repeat (30) @(negedge clk);
        check("lit_code_1c", {24'd0, bus.scan_code}, 32'h1C);

        send_frame(8'h1C, 1'b1, 1'b1, c_HALF);
        repeat (30) @(negedge clk);
        check("lit_code_after_perr", {24'd0, bus.scan_code}, 32'h1C);

        send_frame(8'hF0, 1'b0, 1'b0, c_HALF);
        repeat (30) @(negedge clk);
        check("lit_code_after_ferr", {24'd0, bus.scan_code}, 32'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, c_HALF);
        repeat (30) @(negedge clk);

        partial(8'h5A, 5, t);
        e = '{default: 0};
        e.at   = t + 3 + c_TO;
        e.terr = 1'b1;
        evq.push_back(e);
        busy_hi = t + 3 + c_TO;
        repeat (c_TO + 10) @(negedge clk);
        check("lit_busy_after_timeout", {31'd0, bus.busy}, 32'h0);
        send_frame(8'h5A, 1'b0, 1'b1, c_HALF);
        repeat (30) @(negedge clk);
        check("lit_code_5a", {24'd0, bus.scan_code}, 32'h5A);

        send_frame(8'hE0, 1'b0, 1'b1, c_HALF);
        send_frame(8'h74, 1'b0, 1'b1, 4);
        repeat (30) @(negedge clk);
        check("lit_code_74", {24'd0, bus.scan_code}, 32'h74);

        fall_low(1'b1, c_HALF, t);
        release_clk();
        repeat (30) @(negedge clk);
        check("lit_busy_spurious", {31'd0, bus.busy}, 32'h0);

        partial(8'h29, 5, t);
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        rst_at  = cyc + 1;
        busy_hi = cyc + 1;
        @(negedge clk);
        rst = 1'b1;
        check("lit_code_after_rst", {24'd0, bus.scan_code}, 32'h00);
        repeat (10) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b1, c_HALF);
        repeat (30) @(negedge clk);
        check("lit_code_29", {24'd0, bus.scan_code}, 32'h29);

        check("pending_events", evq.size(), 32'd0);
        check("valid_pulse_count", n_valid, 32'd6);
        check("timeout_pulse_count", n_to, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
